// File: rtl/pad_word_serdes.sv
// Pin-reducing pad I/O stage: PAD_W-bit beats <-> DATA_W-bit core words, LSB beat first.
// Optional PAD_LOOPBACK_EN macro adds an lpbk port routing pad_out back into the capture register.
module pad_word_serdes #(
  parameter int DATA_W = 16,
  parameter int PAD_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PAD_W-1:0]  pad_in_data,
  input  logic              pad_in_valid,
  output logic              pad_in_ready,
  output logic [DATA_W-1:0] core_in_data,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  input  logic [DATA_W-1:0] core_out_data,
  input  logic              core_out_valid,
  output logic              core_out_ready,
  output logic [PAD_W-1:0]  pad_out_data,
  output logic              pad_out_valid,
  output logic              rx_overflow
`ifdef PAD_LOOPBACK_EN
  ,
  input  logic              lpbk
`endif
);

  localparam int BEATS = DATA_W / PAD_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  localparam logic [0:0] RX_FILL = 1'b0;
  localparam logic [0:0] RX_HOLD = 1'b1;
  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_SEND = 1'b1;

  // ---------------- input capture ----------------
  logic [PAD_W-1:0] cap_src_data;
  logic             cap_src_valid;
  logic [PAD_W-1:0] cap_data_q;
  logic             cap_valid_q;
  logic [PAD_W-1:0] pad_out_data_q, pad_out_data_d;
  logic             pad_out_valid_q, pad_out_valid_d;

  always_comb begin
`ifdef PAD_LOOPBACK_EN
    cap_src_data  = lpbk ? pad_out_data_q  : pad_in_data;
    cap_src_valid = lpbk ? pad_out_valid_q : pad_in_valid;
`else
    cap_src_data  = pad_in_data;
    cap_src_valid = pad_in_valid;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      cap_data_q  <= cap_src_data;
      cap_valid_q <= cap_src_valid;
    end
  end

  // ---------------- RX deserialiser ----------------
  logic [0:0]        rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] rx_word_q, rx_word_d;
  logic              rx_ovf_q, rx_ovf_d;
  logic              pad_in_ready_q;
  logic              rx_wr_en;
  logic [CNT_W-1:0]  rx_wr_idx;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_word_d  = rx_word_q;
    rx_ovf_d   = rx_ovf_q;
    rx_wr_en   = 1'b0;
    rx_wr_idx  = rx_cnt_q;
    case (rx_state_q)
      RX_FILL: begin
        if (cap_valid_q) begin
          rx_wr_en = 1'b1;
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_d   = '0;
            rx_state_d = RX_HOLD;
          end else begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
        end
      end
      RX_HOLD: begin
        // A beat arriving on the hand-off cycle starts the next word instead of being dropped.
        if (core_in_ready) begin
          rx_state_d = RX_FILL;
          if (cap_valid_q) begin
            rx_wr_en  = 1'b1;
            rx_wr_idx = '0;
            rx_cnt_d  = CNT_W'(1);
          end
        end else if (cap_valid_q) begin
          rx_ovf_d = 1'b1;
        end
      end
      default: rx_state_d = RX_FILL;
    endcase
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (rx_wr_en && (rx_wr_idx == CNT_W'(b))) begin
        rx_word_d[b*PAD_W +: PAD_W] = cap_data_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q     <= RX_FILL;
      rx_cnt_q       <= '0;
      rx_word_q      <= '0;
      rx_ovf_q       <= 1'b0;
      pad_in_ready_q <= 1'b0;
    end else begin
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_word_q      <= rx_word_d;
      rx_ovf_q       <= rx_ovf_d;
      pad_in_ready_q <= (rx_state_d == RX_FILL);
    end
  end

  assign pad_in_ready  = pad_in_ready_q;
  assign core_in_data  = rx_word_q;
  assign core_in_valid = (rx_state_q == RX_HOLD) & ~rst;
  assign rx_overflow   = rx_ovf_q;

  // ---------------- TX serialiser ----------------
  logic [0:0]        tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [DATA_W-1:0] tx_word_q, tx_word_d;

  always_comb begin
    tx_state_d      = tx_state_q;
    tx_cnt_d        = tx_cnt_q;
    tx_word_d       = tx_word_q;
    pad_out_data_d  = pad_out_data_q;
    pad_out_valid_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (core_out_valid) begin
          tx_word_d  = core_out_data;
          tx_cnt_d   = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        pad_out_valid_d = 1'b1;
        for (int unsigned b = 0; b < BEATS; b++) begin
          if (tx_cnt_q == CNT_W'(b)) begin
            pad_out_data_d = tx_word_q[b*PAD_W +: PAD_W];
          end
        end
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q      <= TX_IDLE;
      tx_cnt_q        <= '0;
      tx_word_q       <= '0;
      pad_out_data_q  <= '0;
      pad_out_valid_q <= 1'b0;
    end else begin
      tx_state_q      <= tx_state_d;
      tx_cnt_q        <= tx_cnt_d;
      tx_word_q       <= tx_word_d;
      pad_out_data_q  <= pad_out_data_d;
      pad_out_valid_q <= pad_out_valid_d;
    end
  end

  assign core_out_ready = (tx_state_q == TX_IDLE) & ~rst;
  assign pad_out_data   = pad_out_data_q;
  assign pad_out_valid  = pad_out_valid_q;

endmodule

// File: tb/tb_pad_word_serdes.sv
// Self-checking bench for pad_word_serdes (DATA_W=16, PAD_W=4): directed scenarios plus
// randomized RX/TX streams checked against word-level queues.
module tb_pad_word_serdes;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pad_in_data;
  logic        pad_in_valid;
  logic        pad_in_ready;
  logic [15:0] core_in_data;
  logic        core_in_valid;
  logic        core_in_ready;
  logic [15:0] core_out_data;
  logic        core_out_valid;
  logic        core_out_ready;
  logic [3:0]  pad_out_data;
  logic        pad_out_valid;
  logic        rx_overflow;
`ifdef PAD_LOOPBACK_EN
  logic        lpbk;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic       tx_mon_en = 1'b0;
  logic [3:0] tx_beats[$];

  pad_word_serdes #(.DATA_W(16), .PAD_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .pad_in_data    (pad_in_data),
    .pad_in_valid   (pad_in_valid),
    .pad_in_ready   (pad_in_ready),
    .core_in_data   (core_in_data),
    .core_in_valid  (core_in_valid),
    .core_in_ready  (core_in_ready),
    .core_out_data  (core_out_data),
    .core_out_valid (core_out_valid),
    .core_out_ready (core_out_ready),
    .pad_out_data   (pad_out_data),
    .pad_out_valid  (pad_out_valid),
    .rx_overflow    (rx_overflow)
`ifdef PAD_LOOPBACK_EN
    ,
    .lpbk           (lpbk)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (tx_mon_en && pad_out_valid) tx_beats.push_back(pad_out_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one word LSB nibble first on consecutive cycles; ends one edge after the last beat.
  task automatic send_beats(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      pad_in_valid = 1'b1;
      pad_in_data  = w[i*4 +: 4];
      step();
    end
    pad_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({core_in_valid, core_in_data, pad_in_ready, core_out_ready, pad_out_data, pad_out_valid, rx_overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got civ=%b cid=%h pir=%b cor=%b pod=%h pov=%b ovf=%b, required all 0",
               core_in_valid, core_in_data, pad_in_ready, core_out_ready, pad_out_data, pad_out_valid, rx_overflow);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (pad_in_ready !== 1'b1 || core_out_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got pad_in_ready=%b core_out_ready=%b, required 1 1", pad_in_ready, core_out_ready);
    end
  endtask

  task automatic test_rx_basic();
    core_in_ready = 1'b0;
    send_beats(16'hABCD);
    n_checks++;
    if (core_in_valid !== 1'b0 || pad_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_latency_early: got valid=%b pad_in_ready=%b, required 0 1", core_in_valid, pad_in_ready);
    end
    step();
    n_checks++;
    if (core_in_valid !== 1'b1 || core_in_data !== 16'hABCD || pad_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_word: got valid=%b data=%h pad_in_ready=%b, required 1 abcd 0", core_in_valid, core_in_data, pad_in_ready);
    end
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (core_in_valid !== 1'b1 || core_in_data !== 16'hABCD) begin
      n_fail++;
      $display("FAIL rx_hold: got valid=%b data=%h, required 1 abcd", core_in_valid, core_in_data);
    end
    core_in_ready = 1'b1;
    step();
    core_in_ready = 1'b0;
    n_checks++;
    if (core_in_valid !== 1'b0 || pad_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_release: got valid=%b pad_in_ready=%b, required 0 1", core_in_valid, pad_in_ready);
    end
  endtask

  task automatic test_tx_basic();
    logic [15:0] w;
    w = 16'h1234;
    core_out_valid = 1'b1;
    core_out_data  = w;
    step();
    core_out_valid = 1'b0;
    n_checks++;
    if (core_out_ready !== 1'b0 || pad_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_accept: got core_out_ready=%b pad_out_valid=%b, required 0 0", core_out_ready, pad_out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (pad_out_valid !== 1'b1 || pad_out_data !== w[i*4 +: 4] || core_out_ready !== (i == 3)) begin
        n_fail++;
        $display("FAIL tx_beat%0d: got valid=%b data=%h ready=%b, required 1 %h %b",
                 i, pad_out_valid, pad_out_data, core_out_ready, w[i*4 +: 4], (i == 3));
      end
    end
    step();
    n_checks++;
    if (pad_out_valid !== 1'b0 || core_out_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_done: got valid=%b ready=%b, required 0 1", pad_out_valid, core_out_ready);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] got[$];
    logic [3:0]  beats[8];
    beats = '{4'hB, 4'hA, 4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4};
    core_in_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      pad_in_valid = (c < 8);
      pad_in_data  = (c < 8) ? beats[c] : 4'h0;
      if (core_in_valid && core_in_ready) got.push_back(core_in_data);
      step();
    end
    pad_in_valid  = 1'b0;
    core_in_ready = 1'b0;
    n_checks++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL simul_count: got %0d words, required 2", got.size());
    end else begin
      n_checks++;
      if (got[0] !== 16'h89AB || got[1] !== 16'h4567) begin
        n_fail++;
        $display("FAIL simul_words: got %h %h, required 89ab 4567", got[0], got[1]);
      end
    end
    n_checks++;
    if (rx_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_overflow: got %b, required 0", rx_overflow);
    end
  endtask

  task automatic test_overflow();
    core_in_ready = 1'b0;
    send_beats(16'hABCD);
    step();
    n_checks++;
    if (pad_in_ready !== 1'b0 || rx_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_pre: got pad_in_ready=%b ovf=%b, required 0 0", pad_in_ready, rx_overflow);
    end
    pad_in_valid = 1'b1;
    pad_in_data  = 4'hE;
    step();
    pad_in_valid = 1'b0;
    step();
    n_checks++;
    if (rx_overflow !== 1'b1 || pad_in_ready !== 1'b0 || core_in_valid !== 1'b1 || core_in_data !== 16'hABCD) begin
      n_fail++;
      $display("FAIL ovf: got ovf=%b pad_in_ready=%b valid=%b data=%h, required 1 0 1 abcd",
               rx_overflow, pad_in_ready, core_in_valid, core_in_data);
    end
    core_in_ready = 1'b1;
    step();
    core_in_ready = 1'b0;
    step();
    n_checks++;
    if (rx_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b, required 1", rx_overflow);
    end
  endtask

  task automatic test_reset_mid_word();
    core_out_valid = 1'b1;
    core_out_data  = 16'hFFFF;
    step();
    core_out_valid = 1'b0;
    pad_in_valid   = 1'b1;
    pad_in_data    = 4'h9;
    step();
    step();
    pad_in_valid = 1'b0;
    rst = 1'b1;
    step();
    n_checks++;
    if (rx_overflow !== 1'b0 || pad_out_valid !== 1'b0 || core_in_valid !== 1'b0 || core_out_ready !== 1'b0 || pad_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_in_reset: got ovf=%b pov=%b civ=%b cor=%b pir=%b, required all 0",
               rx_overflow, pad_out_valid, core_in_valid, core_out_ready, pad_in_ready);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (core_out_ready !== 1'b1 || pad_in_ready !== 1'b1 || pad_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_release: got cor=%b pir=%b pov=%b, required 1 1 0", core_out_ready, pad_in_ready, pad_out_valid);
    end
    send_beats(16'h4321);
    n_checks++;
    if (pad_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_tx_discard: got pad_out_valid=%b, required 0", pad_out_valid);
    end
    step();
    n_checks++;
    if (core_in_valid !== 1'b1 || core_in_data !== 16'h4321 || rx_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_word: got valid=%b data=%h ovf=%b, required 1 4321 0", core_in_valid, core_in_data, rx_overflow);
    end
    core_in_ready = 1'b1;
    step();
    core_in_ready = 1'b0;
  endtask

  task automatic test_random_rx();
    logic [15:0] exp_q[$];
    logic [15:0] got[$];
    logic [3:0]  bd[$];
    logic        bv[$];
    logic [15:0] w;
    for (int k = 0; k < 20; k++) begin
      w = 16'($urandom);
      exp_q.push_back(w);
      for (int b = 0; b < 4; b++) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          bd.push_back(4'($urandom));
          bv.push_back(1'b0);
        end
        bd.push_back(w[b*4 +: 4]);
        bv.push_back(1'b1);
      end
    end
    core_in_ready = 1'b1;
    for (int c = 0; c < bd.size() + 6; c++) begin
      pad_in_valid = (c < bd.size()) ? bv[c] : 1'b0;
      pad_in_data  = (c < bd.size()) ? bd[c] : 4'h0;
      if (core_in_valid && core_in_ready) got.push_back(core_in_data);
      step();
    end
    pad_in_valid  = 1'b0;
    core_in_ready = 1'b0;
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_rx_count: got %0d words, required %0d", got.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (got[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL rand_rx_word%0d: got %h, required %h", k, got[k], exp_q[k]);
        end
      end
    end
    n_checks++;
    if (rx_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_rx_overflow: got %b, required 0", rx_overflow);
    end
  endtask

  task automatic test_random_tx();
    logic [15:0] exp_q[$];
    logic [15:0] w;
    int          guard;
    tx_beats.delete();
    tx_mon_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      w = 16'($urandom);
      exp_q.push_back(w);
      guard = 0;
      while (!core_out_ready && guard < 20) begin
        step();
        guard++;
      end
      n_checks++;
      if (!core_out_ready) begin
        n_fail++;
        $display("FAIL rand_tx_ready_timeout: got core_out_ready=%b, required 1 within 20 cycles", core_out_ready);
      end
      core_out_valid = 1'b1;
      core_out_data  = w;
      step();
      core_out_valid = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end
    for (int i = 0; i < 8; i++) step();
    tx_mon_en = 1'b0;
    n_checks++;
    if (tx_beats.size() != 80) begin
      n_fail++;
      $display("FAIL rand_tx_beats: got %0d beats, required 80", tx_beats.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        w = {tx_beats[4*k+3], tx_beats[4*k+2], tx_beats[4*k+1], tx_beats[4*k]};
        n_checks++;
        if (w !== exp_q[k]) begin
          n_fail++;
          $display("FAIL rand_tx_word%0d: got %h, required %h", k, w, exp_q[k]);
        end
      end
    end
  endtask

`ifdef PAD_LOOPBACK_EN
  task automatic test_loopback();
    int guard;
    lpbk = 1'b1;
    core_out_valid = 1'b1;
    core_out_data  = 16'h5A5A;
    step();
    core_out_valid = 1'b0;
    guard = 0;
    while (!core_in_valid && guard < 12) begin
      step();
      guard++;
    end
    n_checks++;
    if (core_in_valid !== 1'b1 || core_in_data !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL loopback: got valid=%b data=%h, required 1 5a5a", core_in_valid, core_in_data);
    end
    core_in_ready = 1'b1;
    step();
    core_in_ready = 1'b0;
    step();
    lpbk = 1'b0;
  endtask
`endif

  initial begin
    rst            = 1'b1;
    pad_in_data    = '0;
    pad_in_valid   = 1'b0;
    core_in_ready  = 1'b0;
    core_out_data  = '0;
    core_out_valid = 1'b0;
`ifdef PAD_LOOPBACK_EN
    lpbk           = 1'b0;
`endif
    test_reset();
    test_rx_basic();
    test_tx_basic();
    test_simultaneous();
    test_overflow();
    test_reset_mid_word();
    test_random_rx();
    test_random_tx();
`ifdef PAD_LOOPBACK_EN
    test_loopback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
